// File: rtl/draw_pkg.sv
// Shared types and constants for the shape drawers.
// State encoding, octant index and coordinate-width helper.
package draw_pkg;

    typedef enum logic [1:0] {
        IDLE,
        INIT,
        PLOT,
        DONE
    } state_t;

    typedef logic [2:0] oct_t;

    localparam int DEF_SCREEN_W = 160;
    localparam int DEF_SCREEN_H = 120;

    // Signed width wide enough that centre +/- offset never wraps.
    function automatic int coord_w(input int xw, input int yw, input int rw);
        int m;
        m = xw;
        if (yw > m) m = yw;
        if (rw > m) m = rw;
        return m + 2;
    endfunction

endpackage

// File: rtl/circle_octant_map.sv
// Maps a first-octant offset (ox, oy) to one of eight symmetric pixels.
// Purely combinational; also reports whether the pixel is on screen.
module circle_octant_map
    import draw_pkg::*;
#(
    parameter int CW       = 10,
    parameter int SCREEN_W = DEF_SCREEN_W,
    parameter int SCREEN_H = DEF_SCREEN_H
) (
    input  logic signed [CW-1:0] cx,
    input  logic signed [CW-1:0] cy,
    input  logic signed [CW-1:0] ox,
    input  logic signed [CW-1:0] oy,
    input  oct_t                 oct,
    output logic signed [CW-1:0] x,
    output logic signed [CW-1:0] y,
    output logic                 in_bounds
);

    localparam logic signed [CW-1:0] XMAX = CW'(SCREEN_W);
    localparam logic signed [CW-1:0] YMAX = CW'(SCREEN_H);

    // Select the reflection for the current octant slot.
    always_comb begin
        x = cx;
        y = cy;
        unique case (oct)
            3'd0: begin x = cx + ox; y = cy + oy; end
            3'd1: begin x = cx + oy; y = cy + ox; end
            3'd2: begin x = cx - oy; y = cy + ox; end
            3'd3: begin x = cx - ox; y = cy + oy; end
            3'd4: begin x = cx - ox; y = cy - oy; end
            3'd5: begin x = cx - oy; y = cy - ox; end
            3'd6: begin x = cx + oy; y = cy - ox; end
            3'd7: begin x = cx + ox; y = cy - oy; end
        endcase
    end

    // Sign bit clear means non-negative; upper limits compared signed.
    always_comb begin
        in_bounds = !x[CW-1] && (x < XMAX) && !y[CW-1] && (y < YMAX);
    end

endmodule

// File: rtl/arc_drawer.sv
// Bresenham circle/arc engine with per-octant enable mask and clipping.
// Optional pixel counter enabled by defining ARC_DRAWER_PIXEL_COUNT_EN.
module arc_drawer
    import draw_pkg::*;
#(
    parameter int SCREEN_W = DEF_SCREEN_W,
    parameter int SCREEN_H = DEF_SCREEN_H,
    parameter int XW       = 8,
    parameter int YW       = 7,
    parameter int RW       = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [XW-1:0] centre_x,
    input  logic [YW-1:0] centre_y,
    input  logic [RW-1:0] radius,
    input  logic [7:0]    octant_mask,
    input  logic [2:0]    colour,
    output logic          done,
    output logic [XW-1:0] vga_x,
    output logic [YW-1:0] vga_y,
    output logic [2:0]    vga_colour,
    output logic          vga_plot
`ifdef ARC_DRAWER_PIXEL_COUNT_EN
    ,
    output logic [15:0]   pixel_count
`endif
);

    localparam int CW  = coord_w(XW, YW, RW);
    localparam int CRW = RW + 3;
    localparam int AW  = ((CW > CRW) ? CW : CRW) + 1;

    state_t state, next_state;

    logic signed [CW-1:0]  cx_q, cy_q;
    logic signed [CW-1:0]  ox, oy;
    logic signed [CRW-1:0] crit;
    logic [7:0]            mask_q;
    logic [2:0]            col_q;
    oct_t                  oct;

    logic signed [CW-1:0]  ox_n, oy_n;
    logic signed [CRW-1:0] crit_n;
    logic signed [AW-1:0]  ox_a, oy_a, cr_a, step;
    logic                  crit_le0;
    logic                  more;

    logic signed [CW-1:0]  mx, my;
    logic                  inb;
    logic                  plot_c;
    logic                  unused_hi;

    circle_octant_map #(
        .CW       (CW),
        .SCREEN_W (SCREEN_W),
        .SCREEN_H (SCREEN_H)
    ) u_map (
        .cx        (cx_q),
        .cy        (cy_q),
        .ox        (ox),
        .oy        (oy),
        .oct       (oct),
        .x         (mx),
        .y         (my),
        .in_bounds (inb)
    );

    // In-bounds pixels never use the upper bits of the wide coordinates.
    assign unused_hi = ^{mx[CW-1:XW], my[CW-1:YW]};

    // Midpoint step applied after the octant-8 slot of each iteration.
    always_comb begin
        crit_le0 = crit[CRW-1] || (crit == '0);
        oy_n     = oy + CW'(1);
        ox_n     = crit_le0 ? ox : (ox - CW'(1));
        oy_a     = AW'(oy_n);
        ox_a     = AW'(ox_n);
        cr_a     = AW'(crit);
        if (crit_le0) begin
            step = oy_a + oy_a + AW'(1);
        end else begin
            step = (oy_a - ox_a) + (oy_a - ox_a) + AW'(1);
        end
        crit_n = CRW'(cr_a + step);
        more   = (oy_n <= ox_n);
    end

    // Pixel strobe for the current slot, before output registering.
    always_comb begin
        plot_c = (state == PLOT) && mask_q[oct] && inb;
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; DONE holds until done is visible and start drops.
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE: if (start) next_state = INIT;
            INIT: next_state = PLOT;
            PLOT: begin
                if (oct == 3'd7) begin
                    next_state = more ? PLOT : DONE;
                end
            end
            DONE: if (done && !start) next_state = IDLE;
        endcase
    end

    // Latch the job in INIT, walk octant slots and iterate in PLOT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cx_q   <= '0;
            cy_q   <= '0;
            ox     <= '0;
            oy     <= '0;
            crit   <= '0;
            mask_q <= '0;
            col_q  <= '0;
            oct    <= '0;
        end else begin
            unique case (state)
                INIT: begin
                    cx_q   <= CW'(centre_x);
                    cy_q   <= CW'(centre_y);
                    ox     <= CW'(radius);
                    oy     <= '0;
                    crit   <= CRW'(1) - CRW'(radius);
                    mask_q <= octant_mask;
                    col_q  <= colour;
                    oct    <= '0;
                end
                PLOT: begin
                    oct <= oct + 3'd1;
                    if (oct == 3'd7) begin
                        ox   <= ox_n;
                        oy   <= oy_n;
                        crit <= crit_n;
                    end
                end
                default: ;
            endcase
        end
    end

    // Registered outputs; unused coordinates are forced to zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done       <= 1'b0;
            vga_plot   <= 1'b0;
            vga_x      <= '0;
            vga_y      <= '0;
            vga_colour <= '0;
        end else begin
            done       <= (state == DONE) && !(done && !start);
            vga_plot   <= plot_c;
            vga_x      <= plot_c ? mx[XW-1:0] : '0;
            vga_y      <= plot_c ? my[YW-1:0] : '0;
            vga_colour <= (state == PLOT) ? col_q : 3'd0;
        end
    end

`ifdef ARC_DRAWER_PIXEL_COUNT_EN
    // Saturating count of strobed pixels for the most recent draw.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pixel_count <= '0;
        end else if (state == INIT) begin
            pixel_count <= '0;
        end else if (vga_plot && (pixel_count != 16'hFFFF)) begin
            pixel_count <= pixel_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_arc_drawer.sv
// Scoreboard bench for arc_drawer: directed draws, clipping, handshake, reset.
// Expected pixels are queued by the stimulus; a monitor compares each strobe.
module tb_arc_drawer;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] centre_x;
    logic [6:0] centre_y;
    logic [7:0] radius;
    logic [7:0] octant_mask;
    logic [2:0] colour;
    logic       done;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] vga_colour;
    logic       vga_plot;
`ifdef ARC_DRAWER_PIXEL_COUNT_EN
    logic [15:0] pixel_count;
`endif

    arc_drawer dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .centre_x    (centre_x),
        .centre_y    (centre_y),
        .radius      (radius),
        .octant_mask (octant_mask),
        .colour      (colour),
        .done        (done),
        .vga_x       (vga_x),
        .vga_y       (vga_y),
        .vga_colour  (vga_colour),
        .vga_plot    (vga_plot)
`ifdef ARC_DRAWER_PIXEL_COUNT_EN
        ,
        .pixel_count (pixel_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] c;
    } pix_t;

    pix_t sb[$];
    pix_t exp_p;
    int   checks = 0;
    int   passes = 0;
    int   plots  = 0;
    bit   count_only = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic push(input int x, input int y, input int c);
        pix_t p;
        p.x = x[7:0];
        p.y = y[6:0];
        p.c = c[2:0];
        sb.push_back(p);
    endtask

    // Monitor: pop and compare on every pixel strobe.
    always @(posedge clk) begin
        #1;
        if (vga_plot) begin
            plots++;
            if (!count_only) begin
                if (sb.size() == 0) begin
                    checks++;
                    $display("FAIL unexpected_plot: got (%0d,%0d) expected none",
                             vga_x, vga_y);
                end else begin
                    exp_p = sb.pop_front();
                    check("pix_x", vga_x, exp_p.x);
                    check("pix_y", vga_y, exp_p.y);
                    check("pix_colour", vga_colour, exp_p.c);
                end
            end
        end
    end

    task automatic run_draw(input int cx, input int cy, input int r,
                            input int mask, input int col,
                            input int exp_edges, input bit scramble,
                            input string tag);
        int n;
        plots = 0;
        @(negedge clk);
        centre_x    = cx[7:0];
        centre_y    = cy[6:0];
        radius      = r[7:0];
        octant_mask = mask[7:0];
        colour      = col[2:0];
        start       = 1'b1;
        @(posedge clk);
        #1;
        n = 0;
        while (n < 2000) begin
            @(posedge clk);
            #1;
            n++;
            if (n == 1) begin
                check({tag, "_init_noplot"}, vga_plot, 0);
                if (scramble) begin
                    centre_x    = 8'd0;
                    centre_y    = 7'd0;
                    radius      = 8'd200;
                    octant_mask = 8'h00;
                    colour      = 3'd0;
                end
            end
            if (done) break;
        end
        check({tag, "_latency"}, n, exp_edges);
        check({tag, "_done_noplot"}, vga_plot, 0);
        check({tag, "_done_x0"}, vga_x, 0);
        check({tag, "_sb_empty"}, sb.size(), 0);
    endtask

    task automatic end_draw(input string tag);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        #1;
        check({tag, "_done_clear"}, done, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst         = 1'b1;
        start       = 1'b0;
        centre_x    = '0;
        centre_y    = '0;
        radius      = '0;
        octant_mask = '0;
        colour      = '0;
        #1;
        check("rst_done", done, 0);
        check("rst_plot", vga_plot, 0);
        check("rst_xy", {vga_x, vga_y}, 0);
        check("rst_colour", vga_colour, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // r=0: centre emitted in all eight slots.
        repeat (8) push(80, 60, 5);
        run_draw(80, 60, 0, 8'hFF, 5, 10, 1'b0, "r0");
`ifdef ARC_DRAWER_PIXEL_COUNT_EN
        check("r0_count", pixel_count, 8);
`endif
        end_draw("r0");

        // r=1, octant 1 only; inputs scrambled after INIT.
        push(81, 60, 3);
        push(81, 61, 3);
        run_draw(80, 60, 1, 8'h01, 3, 18, 1'b1, "r1");
        check("r1_plots", plots, 2);
`ifdef ARC_DRAWER_PIXEL_COUNT_EN
        check("r1_count", pixel_count, 2);
`endif
        end_draw("r1");

        // Corner centre: negative coordinates clipped.
        push(2, 0, 7);
        push(0, 2, 7);
        push(0, 2, 7);
        push(2, 0, 7);
        push(2, 1, 7);
        push(1, 2, 7);
        run_draw(0, 0, 2, 8'hFF, 7, 18, 1'b0, "clip");
        check("clip_plots", plots, 6);
        end_draw("clip");

        // r=10 with empty mask: eight iterations, no pixels.
        run_draw(80, 60, 10, 8'h00, 4, 66, 1'b0, "m00");
        check("m00_plots", plots, 0);
        end_draw("m00");

        // r=10 full mask: same latency, 64 pixels; start held afterwards.
        count_only = 1'b1;
        run_draw(80, 60, 10, 8'hFF, 4, 66, 1'b0, "mff");
        check("mff_plots", plots, 64);
        count_only = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("hold_done", done, 1);
        check("hold_plots", plots, 64);
        end_draw("hold");
        repeat (3) @(posedge clk);
        #1;
        check("idle_done", done, 0);
        check("idle_plots", plots, 64);

        // Fresh draw with new inputs, octant 8 only.
        push(11, 20, 2);
        push(11, 19, 2);
        run_draw(10, 20, 1, 8'h80, 2, 18, 1'b0, "re");
        end_draw("re");

        // Reset asserted mid-PLOT, away from a clock edge.
        count_only = 1'b1;
        @(negedge clk);
        centre_x    = 8'd80;
        centre_y    = 7'd60;
        radius      = 8'd10;
        octant_mask = 8'hFF;
        colour      = 3'd6;
        start       = 1'b1;
        repeat (20) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("arst_plot", vga_plot, 0);
        check("arst_xy", {vga_x, vga_y}, 0);
        check("arst_colour", vga_colour, 0);
        check("arst_done", done, 0);
`ifdef ARC_DRAWER_PIXEL_COUNT_EN
        check("arst_count", pixel_count, 0);
`endif
        start = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        count_only = 1'b0;

        // Full draw after reset, at the bottom-right corner.
        repeat (4) push(159, 119, 1);
        run_draw(159, 119, 0, 8'h0F, 1, 10, 1'b0, "post");
        end_draw("post");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/arc_drawer.md
Name: arc_drawer

Overview:
- Parametrised Bresenham circle/arc engine for the VGA framebuffer path.
- Successor to the fixed-size shape drawers: screen size and coordinate widths are parameters, and an 8-bit octant mask selects which octants are drawn, so arcs, circles and Reuleaux-style composites can be built.
- Emits at most one clipped pixel per cycle to the VGA adapter, using the start/done handshake.

Parameters:
SCREEN_W, 160, screen width in pixels; valid x is 0..SCREEN_W-1
SCREEN_H, 120, screen height in pixels; valid y is 0..SCREEN_H-1
XW, 8, x coordinate width
YW, 7, y coordinate width
RW, 8, radius width

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
start  in  1  request; sampled in IDLE
centre_x  in  XW  circle centre x
centre_y  in  YW  circle centre y
radius  in  RW  radius, 0 allowed
octant_mask  in  8  bit k-1 enables octant k
colour  in  3  pixel colour
done  out  1  drawing complete
vga_x  out  XW  pixel x
vga_y  out  YW  pixel y
vga_colour  out  3  pixel colour
vga_plot  out  1  pixel write strobe

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous and active-high.
- Reset value of all outputs is 0; state goes to IDLE.
- States and transitions:
  - IDLE: waits for start=1, then goes to INIT.
  - INIT: latches centre_x, centre_y, radius, octant_mask and colour; sets ox=radius, oy=0, crit=1-radius.
  - PLOT: runs for octant index 1..8, one cycle per octant.
  - At the end of the octant-8 cycle, the Bresenham step runs: oy+=1; if crit<=0 then crit+=2*oy+1, else ox-=1 and crit+=2*(oy-ox)+1 (updated oy/ox values). If new oy<=ox, return to octant 1; otherwise go to DONE.
  - DONE: done=1, held while start=1. start=0 gives done=0 and IDLE.
- Octant coordinates:
  - 1: (cx+ox, cy+oy)
  - 2: (cx+oy, cy+ox)
  - 3: (cx-oy, cy+ox)
  - 4: (cx-ox, cy+oy)
  - 5: (cx-ox, cy-oy)
  - 6: (cx-oy, cy-ox)
  - 7: (cx+oy, cy-ox)
  - 8: (cx+ox, cy-oy)
- Arithmetic:
  - All coordinate math is signed, width max(XW,YW,RW)+2; no wrap is permitted.
  - crit is signed, width RW+3.
- Plot conditions:
  - vga_plot=1 only in PLOT when the mask bit is set AND 0<=x<SCREEN_W AND 0<=y<SCREEN_H.
  - Otherwise vga_plot=0 and vga_x/vga_y=0.
  - vga_colour equals the latched colour during PLOT, 0 elsewhere.
- Latency:
  - Every octant slot is visited regardless of the mask, so latency is data-independent.
  - For N iterations, done rises 8N+2 edges after the edge that samples start.
  - The first PLOT cycle follows INIT.
- Boundary conditions:
  - radius=0 gives N=1; the centre is emitted for each enabled octant (duplicates allowed).
  - start held high in DONE does not retrigger.
  - Input changes after INIT are ignored.
  - rst mid-draw returns immediately to IDLE with all outputs 0.

Optional Feature:
- Macro: ARC_DRAWER_PIXEL_COUNT_EN.
- Defined:
  - Adds output pixel_count[15:0].
  - Cleared in INIT and incremented on every cycle with vga_plot=1; saturates at 16'hFFFF.
  - Holds its value through DONE and IDLE until the next INIT; reset value is 0.
- Undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- draw_pkg:
  - state enum (IDLE, INIT, PLOT, DONE)
  - octant index typedef (3-bit)
  - default SCREEN_W/SCREEN_H constants
  - signed coordinate width function
- Sub-module circle_octant_map (combinational):
  - Inputs: cx, cy, ox, oy, octant index.
  - Outputs: signed x, y and an in_bounds flag.
  - Kept separate so it can be reused by future filled-shape drawers.

Test Plan:
- r=0, centre (80,60), mask 8'hFF -> eight plots at (80,60); done after 10 edges; vga_plot=0 in INIT and DONE.
- r=1, centre (80,60), mask 8'h01 -> plots (81,60) then (81,61) in octant-1 slots, 7 idle slots each; done after 18 edges.
- Centre (0,0), r=2, mask 8'hFF -> no plot with negative x or y; x,y in {0,1,2} only; latency 8N+2 unchanged.
- mask 8'h00, r=10 -> zero plots; done at the same edge count as with mask 8'hFF.
- Hold start through done, then drop it -> no retrigger; done clears; reasserting start begins a fresh INIT with new inputs.
- rst pulse mid-PLOT -> outputs 0 asynchronously; IDLE; the next start draws completely from INIT.
